// File: rtl/hrm_mem_arbiter.sv
// Shares the single-port HRM data RAM between the CPU datapath and the host/debug port.
// CPU has priority unless halted; the host is guaranteed a slot after HOST_MAX_WAIT lost arbitrations.
module hrm_mem_arbiter #(
   parameter int AW            = 8,
   parameter int DW            = 8,
   parameter int HOST_MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          cpu_halted,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic [DW-1:0] host_rdata,
   output logic          host_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          grant_host
);

   localparam int WCW = $clog2(HOST_MAX_WAIT + 1);
   localparam logic [WCW-1:0] WAIT_MAX = WCW'(HOST_MAX_WAIT);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ACC_CPU   = 3'd1,
      ACC_HOST  = 3'd2,
      DONE_CPU  = 3'd3,
      DONE_HOST = 3'd4
   } state_t;

   state_t         r_state;
   state_t         w_next;
   logic           w_sel_cpu;
   logic           w_sel_host;
   logic           r_mem_en;
   logic           r_mem_we;
   logic [AW-1:0]  r_mem_addr;
   logic [DW-1:0]  r_mem_wdata;
   logic           r_cpu_ack;
   logic           r_host_ack;
   logic [WCW-1:0] r_wait_cnt;

   // Arbitration in IDLE and next-state selection
   always_comb begin
      w_next     = r_state;
      w_sel_cpu  = 1'b0;
      w_sel_host = 1'b0;
      case (r_state)
         IDLE: begin
            if (cpu_halted) begin
               if (host_req) begin
                  w_sel_host = 1'b1;
               end else if (cpu_req) begin
                  w_sel_cpu = 1'b1;
               end else begin
                  w_sel_cpu = 1'b0;
               end
            end else if (host_req && (r_wait_cnt == WAIT_MAX)) begin
               w_sel_host = 1'b1;
            end else if (cpu_req) begin
               w_sel_cpu = 1'b1;
            end else if (host_req) begin
               w_sel_host = 1'b1;
            end else begin
               w_sel_cpu = 1'b0;
            end
            if (w_sel_cpu) begin
               w_next = ACC_CPU;
            end else if (w_sel_host) begin
               w_next = ACC_HOST;
            end else begin
               w_next = IDLE;
            end
         end
         ACC_CPU:   w_next = DONE_CPU;
         ACC_HOST:  w_next = DONE_HOST;
         DONE_CPU:  w_next = IDLE;
         DONE_HOST: w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // State, registered RAM port and ack pulses
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= {AW{1'b0}};
         r_mem_wdata <= {DW{1'b0}};
         r_cpu_ack   <= 1'b0;
         r_host_ack  <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_cpu_ack  <= (r_state == ACC_CPU);
         r_host_ack <= (r_state == ACC_HOST);
         if (w_sel_cpu) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= cpu_we;
            r_mem_addr  <= cpu_addr;
            r_mem_wdata <= cpu_wdata;
         end else if (w_sel_host) begin
            r_mem_en    <= 1'b1;
            r_mem_we    <= host_we;
            r_mem_addr  <= host_addr;
            r_mem_wdata <= host_wdata;
         end else begin
            // address/data hold so the RAM sees a stable bus after the access
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
         end
      end
   end

   // Host starvation counter: counts CPU wins while the host is waiting
   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_wait_cnt <= {WCW{1'b0}};
      end else if (r_state == IDLE) begin
         if (!host_req || w_sel_host) begin
            r_wait_cnt <= {WCW{1'b0}};
         end else if (w_sel_cpu && (r_wait_cnt != WAIT_MAX)) begin
            r_wait_cnt <= r_wait_cnt + WCW'(1);
         end else begin
            r_wait_cnt <= r_wait_cnt;
         end
      end else begin
         r_wait_cnt <= r_wait_cnt;
      end
   end

   assign mem_en     = r_mem_en;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign cpu_ack    = r_cpu_ack;
   assign host_ack   = r_host_ack;
   assign cpu_rdata  = r_cpu_ack ? mem_rdata : {DW{1'b0}};
   assign host_rdata = r_host_ack ? mem_rdata : {DW{1'b0}};
   assign cpu_stall  = cpu_req & ~r_cpu_ack;
   assign grant_host = (r_state == ACC_HOST) || (r_state == DONE_HOST);

endmodule
